// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared constants and helpers for the 5-port mesh router.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int NPORTS = 5;
    localparam int SELW   = 3;

    typedef logic [SELW-1:0] port_idx_t;

    localparam port_idx_t CORE  = 3'd0;
    localparam port_idx_t LINK1 = 3'd1;
    localparam port_idx_t LINK2 = 3'd2;
    localparam port_idx_t LINK3 = 3'd3;
    localparam port_idx_t LINK4 = 3'd4;

    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    // Flit type lives in flit[31:30]
    localparam int FT_MSB = 31;
    localparam int FT_LSB = 30;

    localparam logic ST_FREE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    function automatic port_idx_t next_port(input port_idx_t p);
        return (p == port_idx_t'(NPORTS - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vc_switch_allocator_if.sv
`default_nettype none
// ============================================================================
// Module      : vc_switch_allocator_if
// Description : Request/grant bundle between VC buffers, allocator, crossbar.
// Revision    : 1.0 - initial release
// ============================================================================
interface vc_switch_allocator_if;
    import router_pkg::*;

    logic [NPORTS-1:0]      in_val;
    logic [NPORTS*SELW-1:0] in_dest;
    logic [NPORTS*2-1:0]    in_type;
    logic [NPORTS-1:0]      out_ready;
    logic [NPORTS-1:0]      in_grant;
    logic [NPORTS*SELW-1:0] out_sel;
    logic [NPORTS-1:0]      out_val;
    logic [NPORTS-1:0]      out_busy;
    logic [NPORTS-1:0]      err_stray;

    modport master (
        output in_val, in_dest, in_type, out_ready,
        input  in_grant, out_sel, out_val, out_busy, err_stray
    );

    modport slave (
        input  in_val, in_dest, in_type, out_ready,
        output in_grant, out_sel, out_val, out_busy, err_stray
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter5.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter5
// Description : 5-way round-robin pick, scanning upward from i_ptr with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter5
    import router_pkg::*;
(
    input  wire logic [NPORTS-1:0] i_req,
    input  wire port_idx_t         i_ptr,
    output logic [NPORTS-1:0]      o_gnt,
    output port_idx_t              o_idx,
    output logic                   o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            int idx;
            idx = (int'(i_ptr) + k) % NPORTS;
            if (!o_any && i_req[idx]) begin
                o_any      = 1'b1;
                o_gnt[idx] = 1'b1;
                o_idx      = port_idx_t'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vc_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : vc_switch_allocator
// Description : Per-output round-robin switch allocation with wormhole locks.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_switch_allocator
    import router_pkg::*;
(
    input  wire logic            clk0,
    input  wire logic            reset,
    vc_switch_allocator_if.slave bus
);

    logic [NPORTS-1:0]      r_lock;
    port_idx_t              r_owner [NPORTS];
    port_idx_t              r_ptr   [NPORTS];
    logic [NPORTS-1:0]      r_err;

    port_idx_t              w_dest  [NPORTS];
    logic [1:0]             w_type  [NPORTS];
    logic [NPORTS-1:0]      w_cont;
    logic [NPORTS-1:0]      w_head_vec;
    logic [NPORTS-1:0]      w_owns;
    logic [NPORTS-1:0]      w_err;

    logic [NPORTS-1:0]      w_hreq    [NPORTS];
    logic [NPORTS-1:0]      w_arb_gnt [NPORTS];
    port_idx_t              w_arb_idx [NPORTS];
    logic [NPORTS-1:0]      w_arb_any;
    logic [NPORTS-1:0]      w_own_req;
    logic [NPORTS-1:0]      w_own_tail;

    logic [NPORTS-1:0]      w_oval;
    port_idx_t              w_src [NPORTS];
    logic [NPORTS-1:0]      w_grant;
    logic [NPORTS*SELW-1:0] w_sel;

    logic [NPORTS-1:0]      w_lock_nxt;
    port_idx_t              w_owner_nxt [NPORTS];
    port_idx_t              w_ptr_nxt   [NPORTS];

    // Decode each input's head flit and classify protocol errors
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            w_dest[i]     = bus.in_dest[i*SELW +: SELW];
            w_type[i]     = bus.in_type[i*2 +: 2];
            w_cont[i]     = (w_type[i] == FT_BODY) || (w_type[i] == FT_TAIL);
            w_head_vec[i] = (w_type[i] == FT_HEAD);
            w_owns[i]     = 1'b0;
            for (int o = 0; o < NPORTS; o++) begin
                if (w_dest[i] == port_idx_t'(o) && r_lock[o] == ST_LOCKED &&
                    r_owner[o] == port_idx_t'(i))
                    w_owns[i] = 1'b1;
            end
            // Continuation flits need ownership; packet starts must not have it
            w_err[i] = bus.in_val[i] &&
                       ((w_dest[i] >= port_idx_t'(NPORTS)) || (w_cont[i] != w_owns[i]));
        end
    end

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            w_hreq[o]     = '0;
            w_own_req[o]  = 1'b0;
            w_own_tail[o] = 1'b0;
            for (int i = 0; i < NPORTS; i++) begin
                w_hreq[o][i] = bus.in_val[i] && (w_dest[i] == port_idx_t'(o)) &&
                               !w_cont[i] && !w_err[i];
                if (r_owner[o] == port_idx_t'(i) && bus.in_val[i] &&
                    w_dest[i] == port_idx_t'(o) && w_cont[i]) begin
                    w_own_req[o]  = 1'b1;
                    w_own_tail[o] = (w_type[i] == FT_TAIL);
                end
            end
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_arb
        rr_arbiter5 u_arb (
            .i_req (w_hreq[o]),
            .i_ptr (r_ptr[o]),
            .o_gnt (w_arb_gnt[o]),
            .o_idx (w_arb_idx[o]),
            .o_any (w_arb_any[o])
        );
    end

    // Lock state register
    always_ff @(posedge clk0) begin
        if (reset) begin
            r_lock <= '0;
            r_err  <= '0;
            for (int o = 0; o < NPORTS; o++) begin
                r_owner[o] <= '0;
                r_ptr[o]   <= '0;
            end
        end else begin
            r_lock <= w_lock_nxt;
            r_err  <= w_err;
            for (int o = 0; o < NPORTS; o++) begin
                r_owner[o] <= w_owner_nxt[o];
                r_ptr[o]   <= w_ptr_nxt[o];
            end
        end
    end

    // Next lock state: header grant locks, tail transfer releases
    always_comb begin
        w_lock_nxt = r_lock;
        for (int o = 0; o < NPORTS; o++) begin
            w_owner_nxt[o] = r_owner[o];
            w_ptr_nxt[o]   = r_ptr[o];
            if (w_oval[o]) begin
                if (r_lock[o] == ST_LOCKED) begin
                    if (w_own_tail[o])
                        w_lock_nxt[o] = ST_FREE;
                end else begin
                    w_ptr_nxt[o] = next_port(w_arb_idx[o]);
                    if (|(w_arb_gnt[o] & w_head_vec)) begin
                        w_lock_nxt[o]  = ST_LOCKED;
                        w_owner_nxt[o] = w_arb_idx[o];
                    end
                end
            end
        end
    end

    // Grants and crossbar selects, same cycle as the request
    always_comb begin
        w_oval  = '0;
        w_grant = '0;
        w_sel   = '0;
        for (int o = 0; o < NPORTS; o++) begin
            if (r_lock[o] == ST_LOCKED) begin
                w_oval[o] = w_own_req[o] && bus.out_ready[o];
                w_src[o]  = r_owner[o];
            end else begin
                w_oval[o] = w_arb_any[o] && bus.out_ready[o];
                w_src[o]  = w_arb_idx[o];
            end
            if (reset)
                w_oval[o] = 1'b0;
            if (w_oval[o])
                w_sel[o*SELW +: SELW] = w_src[o];
            for (int i = 0; i < NPORTS; i++) begin
                if (w_oval[o] && w_src[o] == port_idx_t'(i))
                    w_grant[i] = 1'b1;
            end
        end
    end

    assign bus.in_grant  = w_grant;
    assign bus.out_sel   = w_sel;
    assign bus.out_val   = w_oval;
    assign bus.out_busy  = reset ? '0 : r_lock;
    assign bus.err_stray = r_err;

endmodule
`default_nettype wire
